// File: rtl/isqrt_rr_arbiter.sv
// Round-robin front end that shares one pipelined isqrt among N_REQ requesters.
// A tag pipeline matched to the isqrt latency steers each result back to its owner.
module isqrt_rr_arbiter #(
    parameter int N_REQ        = 2,
    parameter int WIDTH        = 32,
    parameter int ISQRT_STAGES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_rdy,
    output logic                       isq_x_vld,
    output logic [WIDTH-1:0]           isq_x,
    input  logic                       isq_y_vld,
    input  logic [WIDTH-1:0]           isq_y,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       err
);
    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   issue_id;
    logic             grant_any;
    logic             handshake;
    logic [WIDTH-1:0] grant_data;

    logic [ISQRT_STAGES-1:0] tag_vld;
    logic [IDW-1:0]          tag_id [ISQRT_STAGES];
    logic                    tail_vld;
    logic [IDW-1:0]          tail_id;

    // Handshake on requester i is req_vld[i] & req_rdy[i]; a requester keeps
    // req_vld/req_data stable until then, and req_rdy never waits on the isqrt.
    always_comb begin
        grant_any  = 1'b0;
        grant_id   = '0;
        scan_idx   = '0;
        grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = IDW'((int'(last_grant) + 1 + k) % N_REQ);
            if (!grant_any && req_vld[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx;
            end
        end
        if (rst) begin
            grant_any = 1'b0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (IDW'(i) == grant_id) begin
                grant_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_rdy   = grant_any ? (N_REQ'(1) << grant_id) : '0;
    assign handshake = |(req_vld & req_rdy);

    // Operand and id hold when idle so the isqrt input does not toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            isq_x_vld  <= 1'b0;
            isq_x      <= '0;
            issue_id   <= '0;
            last_grant <= IDW'(N_REQ - 1);
        end else begin
            isq_x_vld <= handshake;
            if (handshake) begin
                isq_x      <= grant_data;
                issue_id   <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int j = 0; j < ISQRT_STAGES; j++) begin
                tag_id[j] <= '0;
            end
        end else begin
            tag_vld[0] <= isq_x_vld;
            if (isq_x_vld) begin
                tag_id[0] <= issue_id;
            end
            for (int j = 1; j < ISQRT_STAGES; j++) begin
                tag_vld[j] <= tag_vld[j-1];
                if (tag_vld[j-1]) begin
                    tag_id[j] <= tag_id[j-1];
                end
            end
        end
    end

    assign tail_vld = tag_vld[ISQRT_STAGES-1];
    assign tail_id  = tag_id[ISQRT_STAGES-1];

    always_comb begin
        rsp_vld = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_vld[i] = isq_y_vld & tail_vld & (tail_id == IDW'(i));
        end
    end

    assign rsp_id   = tail_id;
    assign rsp_data = isq_y;

    // A result without a tag (or a tag without a result) means the isqrt depth
    // does not match ISQRT_STAGES; latch it until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (isq_y_vld != tail_vld) begin
            err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Bench for isqrt_rr_arbiter: behavioural isqrt pipeline, round-robin grant
// predictor feeding an expected-response queue, and a decoupled response monitor.
module tb_isqrt_rr_arbiter;
    localparam int N   = 3;
    localparam int W   = 32;
    localparam int S   = 4;
    localparam int IDW = $clog2(N);
    localparam int EW  = 32 + IDW + W;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rdy;
    logic           isq_x_vld;
    logic [W-1:0]   isq_x;
    logic           isq_y_vld;
    logic [W-1:0]   isq_y;
    logic [N-1:0]   rsp_vld;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           err;
    logic           force_y;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [EW-1:0] exp_q[$];
    logic [N-1:0]  hs_mask;
    logic [N-1:0]  exp_rdy;
    int            m_last = N - 1;
    int            cand;
    logic          exp_err = 1'b0;

    isqrt_rr_arbiter #(.N_REQ(N), .WIDTH(W), .ISQRT_STAGES(S)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
        .req_rdy(req_rdy), .isq_x_vld(isq_x_vld), .isq_x(isq_x),
        .isq_y_vld(isq_y_vld), .isq_y(isq_y), .rsp_vld(rsp_vld),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_isqrt(input logic [W-1:0] x);
        real    xr;
        longint r;
        longint xl;
        xr = x;
        xl = longint'(x);
        r  = longint'($rtoi($sqrt(xr)));
        while (r * r > xl) r--;
        while ((r + 1) * (r + 1) <= xl) r++;
        return W'(r);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural isqrt: S-cycle pipeline sharing rst; force_y injects a stray result.
    logic         m_vld [S];
    logic [W-1:0] m_y   [S];
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < S; j++) m_vld[j] <= 1'b0;
        end else begin
            m_vld[0] <= isq_x_vld;
            m_y[0]   <= ref_isqrt(isq_x);
            for (int j = 1; j < S; j++) begin
                m_vld[j] <= m_vld[j-1];
                m_y[j]   <= m_y[j-1];
            end
        end
    end
    assign isq_y_vld = m_vld[S-1] | force_y;
    assign isq_y     = m_y[S-1];

    // Predictor: first valid requester after the last grant, wrapping.
    always @(negedge clk) begin
        exp_rdy = '0;
        if (rst) begin
            m_last = N - 1;
            exp_q.delete();
        end else begin
            for (int k = 0; k < N; k++) begin
                cand = (m_last + 1 + k) % N;
                if (exp_rdy == '0 && req_vld[cand]) exp_rdy[cand] = 1'b1;
            end
        end
        check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        hs_mask = exp_rdy;
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                m_last = i;
                exp_q.push_back({32'(cyc + S + 1), IDW'(i), ref_isqrt(req_data[i*W +: W])});
            end
        end
    end

    // Monitor: each queued response must appear exactly on its due cycle.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [N-1:0]  oh;
        logic          due_now;
        if (rst) begin
            exp_err = 1'b0;
        end else begin
            check("err", 64'(err), 64'(exp_err));
            due_now = (exp_q.size() > 0) && (exp_q[0][EW-1 -: 32] == 32'(cyc));
            if (due_now) begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e[W +: IDW]] = 1'b1;
                check("rsp_vld", 64'(rsp_vld), 64'(oh));
                check("rsp_id", 64'(rsp_id), 64'(e[W +: IDW]));
                check("rsp_data", 64'(rsp_data), 64'(e[W-1:0]));
            end else begin
                check("rsp_idle", 64'(rsp_vld), 64'd0);
            end
            exp_err = exp_err | (force_y & ~due_now);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        @(negedge clk);
        check("rst_isq_x_vld", 64'(isq_x_vld), 64'd0);
        check("rst_isq_x", 64'(isq_x), 64'd0);
        check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_err", 64'(err), 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        req_vld = '1;
        repeat (n) step();
        rst     = 1'b0;
        req_vld = '0;
        reset_checks();
        step();
    endtask

    task automatic drop_until_idle(input int max_cyc);
        int t = 0;
        while (req_vld != '0 && t < max_cyc) begin
            step();
            req_vld = req_vld & ~hs_mask;
            t++;
        end
        check("req_drained", 64'(req_vld), 64'd0);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            step();
            t++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int           cnt;
        int           nhs;
        logic [W-1:0] x_hold;
        rst      = 1'b1;
        force_y  = 1'b0;
        req_vld  = '0;
        req_data = '0;
        @(negedge clk);
        #1;
        do_reset(3);

        // Single request: 16 -> 4 after S+1 cycles
        req_data[0 +: W] = 32'd16;
        req_vld = 3'b001;
        drop_until_idle(5);
        wait_drain();

        // Simultaneous first request
        req_data[0 +: W] = 32'd81;
        req_data[W +: W] = 32'd100;
        req_vld = 3'b011;
        drop_until_idle(5);
        wait_drain();

        // Saturation: two requesters, operands 0..7
        req_data[0 +: W] = 32'd0;
        req_data[W +: W] = 32'd1;
        cnt = 2;
        req_vld = 3'b011;
        for (int t = 0; t < 20 && req_vld != '0; t++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (hs_mask[i]) begin
                    if (cnt < 8) begin
                        req_data[i*W +: W] = W'(cnt);
                        cnt++;
                    end else begin
                        req_vld[i] = 1'b0;
                    end
                end
            end
        end
        check("sat_done", 64'(req_vld), 64'd0);
        wait_drain();

        // Idle gating
        step();
        @(negedge clk);
        x_hold = isq_x;
        for (int t = 0; t < 10; t++) begin
            step();
            @(negedge clk);
            check("idle_x_vld", 64'(isq_x_vld), 64'd0);
            check("idle_x", 64'(isq_x), 64'(x_hold));
        end
        step();

        // Reset mid-flight after 3 handshakes
        for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
        req_vld = '1;
        nhs = 0;
        for (int t = 0; t < 10 && nhs < 3; t++) begin
            step();
            for (int i = 0; i < N; i++) if (hs_mask[i]) nhs++;
            req_vld = req_vld & ~hs_mask;
        end
        req_vld = '0;
        step();
        step();
        do_reset(2);
        for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom_range(0, 5000);
        req_vld = '1;
        drop_until_idle(6);
        wait_drain();

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            step();
            req_vld = req_vld & ~hs_mask;
            for (int i = 0; i < N; i++) begin
                if (!req_vld[i] && $urandom_range(0, 99) < 45) begin
                    req_data[i*W +: W] = $urandom_range(0, 1) ? $urandom : W'($urandom_range(0, 1000));
                    req_vld[i] = 1'b1;
                end
            end
        end
        drop_until_idle(10);
        wait_drain();

        // Stray result with an empty tag pipe
        repeat (3) step();
        force_y = 1'b1;
        step();
        force_y = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("err_sticky", 64'(err), 64'd1);
        step();
        do_reset(2);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/isqrt_rr_arbiter.md
# isqrt_rr_arbiter

Round-robin scheduler that shares one pipelined `isqrt` instance among `N_REQ` independent requesters. It accepts at most one operand per cycle, drives the shared `isqrt` input, and tracks each in-flight operation's requester id in a tag pipeline aligned with the `isqrt` latency. Results are steered back to the owning requester. It sits between formula-level datapaths and the `isqrt` block, so that several low-rate users pay for one square-root pipeline instead of one each.

## Interface
- `N_REQ`, default 2: number of requesters, range 2..8.
- `WIDTH`, default 32: operand and result width.
- `ISQRT_STAGES`, default 4: latency of the attached `isqrt`, in cycles from `x_vld` to `y_vld`. Must match the attached `isqrt` instance's pipeline depth.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_vld` in `N_REQ`: per-requester operand valid.
- `req_data` in `N_REQ*WIDTH`: operands; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `req_rdy` out `N_REQ`: one-hot grant. A handshake on requester i occurs when `req_vld[i] & req_rdy[i]`.
- `isq_x_vld` out 1: valid to the shared `isqrt`.
- `isq_x` out `WIDTH`: operand to the shared `isqrt`.
- `isq_y_vld` in 1: result valid from the `isqrt`.
- `isq_y` in `WIDTH`: result from the `isqrt`.
- `rsp_vld` out `N_REQ`: one-hot result valid.
- `rsp_id` out `$clog2(N_REQ)`: owner of the current result.
- `rsp_data` out `WIDTH`: result, common to all requesters.
- `err` out 1: sticky tag/result misalignment flag.

## Operation
- Arbitration is combinational each cycle.
  - Priority starts at `(last_grant+1) mod N_REQ` and searches upward with wrap.
  - `req_rdy` has at most one bit set, and only on a requester with `req_vld` high.
  - `req_rdy` never depends on `isq_y_vld`: the `isqrt` is always ready.
- `last_grant` updates only on a handshake. After reset it equals `N_REQ-1`, so requester 0 has top priority.
- Issue stage (registered):
  - On a handshake: `isq_x_vld<=1`, `isq_x<=req_data[grant]`, `issue_id<=grant`.
  - Otherwise `isq_x_vld<=0`, and `isq_x`/`issue_id` hold their values (no toggling, to save dynamic power).
- Tag pipeline: `ISQRT_STAGES` entries of {vld, id}. It shifts every cycle; its input is {`isq_x_vld`, `issue_id`}. Id fields load only when the entering vld is 1.
- Response path (combinational from the tag-pipe tail and `isqrt` outputs):
  - `rsp_vld[i] = isq_y_vld & tail_vld & (tail_id==i)`.
  - `rsp_id = tail_id`.
  - `rsp_data = isq_y`.
- Error: `err` sets when `isq_y_vld != tail_vld` in any cycle, and clears only on `rst`. When `isq_y_vld` is high with no tag, no `rsp_vld` bit is raised.
- Requester rule: `req_vld`/`req_data` must stay stable until the handshake. This is a verification assertion only; the block does not enforce it.
- There is no backpressure on `rsp`. Requesters must accept results in the cycle they are presented.

## Timing
- Handshake at cycle T:
  - `isq_x_vld=1` at T+1.
  - `isq_y_vld` and `rsp_vld` at T+1+`ISQRT_STAGES`.
  - Fixed latency is `ISQRT_STAGES+1` cycles.
- Throughput: one operation per cycle in aggregate. With k requesters continuously valid, each gets one grant every k cycles.
- Reset:
  - Values while `rst` is high and on the first cycle after: `req_rdy=0`, `isq_x_vld=0`, `isq_x=0`, all tag vld=0, `rsp_vld=0`, `rsp_id=0`, `err=0`, `last_grant=N_REQ-1`.
  - `req_rdy` is forced 0 while `rst` is high.
  - Reset mid-operation discards in-flight tags; the `isqrt` shares `rst`, so no orphan results are expected.
- Simultaneous events: a new issue and a returning result in the same cycle are independent and both proceed.
- A single requester held valid is granted every cycle; round robin does not insert bubbles.

## Test plan
- Single request (`N_REQ`=2, `ISQRT_STAGES`=4): `req_vld[0]=1`, `req_data[0]=16` at cycle 0 after reset → `req_rdy[0]=1` at cycle 0; `rsp_vld=2'b01`, `rsp_data=4` at cycle 5; `err=0`.
- Simultaneous first request: both valid at cycle 0 with data 81 and 100 → grants 0 then 1 on cycles 0 and 1; responses 9 to id 0 at cycle 5, then 10 to id 1 at cycle 6.
- Saturation: both held valid for 8 cycles with data incrementing by 1 from 0 → grants alternate 0,1,0,1…; 8 consecutive `rsp_vld` cycles, each result equal to isqrt of its own operand, and the per-requester order preserved.
- Idle gating: no requests for 10 cycles → `isq_x_vld=0` and `isq_x` constant throughout.
- Reset mid-flight: `rst` asserted 2 cycles after 3 handshakes → no `rsp_vld` after reset; next request granted to requester 0 first.
- Misalignment: drive `isq_y_vld=1` with an empty tag pipe → `rsp_vld=0`, `err=1`, and `err` stays 1 until `rst`.
